// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state encoding and default datapath width
// used by the bit-serial arithmetic blocks.
package arith_pkg;

  // Control states of the bit-serial arithmetic units.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default operand/result width for serial datapath blocks.
  localparam int DEFAULT_WIDTH = 8;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational; meant to be reused by other serial ALU blocks.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~a & bin) | (b & bin);
  end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// LSB first. Operands enter on a valid/ready handshake in IDLE, the result
// leaves on a valid/ready handshake in DONE. Input and output phases never
// overlap, so one operation takes at least WIDTH+2 clocks.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_r;
  state_e             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_bit_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic               overflow_r;
  logic               a_msb_r;
  logic               b_msb_r;
  logic               d_s;
  logic               bout_s;

  // The single arithmetic cell, fed from the operand LSBs and the borrow flop.
  full_subtractor u_fs (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bout_s)
  );

  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: accept in IDLE, shift WIDTH bits, hold DONE until taken.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath: operand load, bit-serial shift, and result/flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      diff_r     <= {WIDTH{1'b0}};
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            borrow_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          diff_r   <= {d_s, diff_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          borrow_r <= bout_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          // d_s on the last bit is the result sign bit.
          if (last_bit_s) begin
            overflow_r <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
          end
        end
        DONE: begin
          // Result held until the consumer takes it.
        end
        default: begin
          // Unreachable encoding; hold.
        end
      endcase
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = (state_r == DONE);
  assign diff       = diff_r;
  assign borrow_out = borrow_r;
  assign overflow   = overflow_r;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// randomized operands against an arithmetic reference model, back-pressure,
// in_valid during busy, and reset mid-operation.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {overflow, borrow, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    int ua, ub, sa, sb, sd;
    logic [W-1:0] md;
    logic mbor, movf;
    ua   = int'(ma);
    ub   = int'(mb);
    sa   = (ua >= 128) ? ua - 256 : ua;
    sb   = (ub >= 128) ? ub - 256 : ub;
    sd   = sa - sb;
    md   = W'((ua - ub + 256) % 256);
    mbor = (ua < ub);
    movf = (sd > 127) || (sd < -128);
    return {movf, mbor, md};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one handshake edge, then drop in_valid.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; check latency, busy in_ready and result.
  task automatic wait_result(input logic [W-1:0] ta, input logic [W-1:0] tb, input string name);
    int cyc;
    logic [W+1:0] exp;
    exp = model(ta, tb);
    cyc = 0;
    while (!out_valid && cyc < 4 * W) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_in_ready: got %b want 0 (cycle %0d)", name, in_ready, cyc);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== W) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, W);
    end
    checks++;
    if (out_valid !== 1'b1 || diff !== exp[W-1:0] || borrow_out !== exp[W] || overflow !== exp[W+1]) begin
      errors++;
      $display("FAIL %s result: got v=%b d=%h b=%b o=%b want v=1 d=%h b=%b o=%b",
               name, out_valid, diff, borrow_out, overflow, exp[W-1:0], exp[W], exp[W+1]);
    end
  endtask

  // Take the result; check return to IDLE with outputs held.
  task automatic accept_result(input string name);
    logic [W-1:0] hd;
    logic hb, ho;
    hd = diff; hb = borrow_out; ho = overflow;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== hd || borrow_out !== hb || overflow !== ho) begin
      errors++;
      $display("FAIL %s accept: got v=%b r=%b d=%h b=%b o=%b want v=0 r=1 d=%h b=%b o=%b",
               name, out_valid, in_ready, diff, borrow_out, overflow, hd, hb, ho);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input string name);
    start_op(ta, tb);
    wait_result(ta, tb, name);
    accept_result(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got r=%b v=%b d=%h b=%b o=%b want r=1 v=0 d=00 b=0 o=0",
               in_ready, out_valid, diff, borrow_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    do_op(8'h05, 8'h03, "vec_05_03");
    do_op(8'h03, 8'h05, "vec_03_05");
    do_op(8'h80, 8'h01, "vec_80_01");
    do_op(8'h7F, 8'hFF, "vec_7f_ff");
    do_op(8'h00, 8'h00, "vec_00_00");
    do_op(8'h00, 8'hFF, "vec_00_ff");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      do_op(ra, rb, "random");
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] hd;
    logic hb, ho;
    start_op(8'h5A, 8'h5A);
    wait_result(8'h5A, 8'h5A, "stall");
    hd = diff; hb = borrow_out; ho = overflow;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== hd || borrow_out !== hb || overflow !== ho) begin
        errors++;
        $display("FAIL stall_hold: got v=%b r=%b d=%h want v=1 r=0 d=%h (cycle %0d)",
                 out_valid, in_ready, diff, hd, i);
      end
    end
    accept_result("stall");
  endtask

  task automatic test_busy_in_valid();
    start_op(8'h10, 8'h01);
    // Second pair held valid through SHIFT and DONE; out_ready high early too.
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    wait_result(8'h10, 8'h01, "busy_first");
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    wait_result(8'hFF, 8'hFF, "busy_second");
    accept_result("busy_second");
  endtask

  task automatic test_reset_mid_shift();
    start_op(8'h05, 8'h03);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 8'h00 || in_ready !== 1'b1 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL abort: got v=%b d=%h r=%b b=%b want v=0 d=00 r=1 b=0",
               out_valid, diff, in_ready, borrow_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(8'h05, 8'h03, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      start_op(ra, rb);
      out_ready = 1'b1;
      wait_result(ra, rb, "b2b");
      accept_result("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_busy_in_valid();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtractor
